// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns one EX/MEM load or store into a single
// word-aligned request/ready bus transaction, with lane steering and extension.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_read_data,
  output logic        mem_wb_load,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_access;
  logic        w_legal;
  logic        w_aligned;
  logic        w_go;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  assign w_access    = mem_load | mem_store;
  assign w_go        = w_access & w_legal & w_aligned;
  assign mem_wb_load = mem_load;
  assign mem_stall   = ((r_state == S_IDLE) & w_go) | (r_state == S_BUSY);

  always_comb begin
    w_legal = 1'b0;
    case (mem_funct3)
      3'b000, 3'b001, 3'b010: w_legal = w_access;
      3'b100, 3'b101:         w_legal = mem_load;
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned = 1'b0;
    case (mem_funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~mem_addr[0];
      2'b10:   w_aligned = (mem_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Store data is replicated across lanes; the strobes pick the live lane.
  always_comb begin
    w_wdata = mem_store_data;
    w_wstrb = 4'hF;
    case (mem_funct3[1:0])
      2'b00: begin
        w_wdata = {4{mem_store_data[7:0]}};
        w_wstrb = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{mem_store_data[15:0]}};
        w_wstrb = 4'b0011 << mem_addr[1:0];
      end
      default: begin
        w_wdata = mem_store_data;
        w_wstrb = 4'hF;
      end
    endcase
  end

  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_off)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_fmt = {24'h0, w_byte};
      3'b101:  w_load_fmt = {16'h0, w_half};
      default: w_load_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_funct3      <= 3'd0;
      r_off         <= 2'd0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'd0;
      bus_wdata     <= 32'd0;
      bus_wstrb     <= 4'd0;
      mem_read_data <= 32'd0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_wdata <= mem_store ? w_wdata : 32'd0;
            bus_wstrb <= mem_store ? w_wstrb : 4'd0;
            r_funct3  <= mem_funct3;
            r_off     <= mem_addr[1:0];
            r_cnt     <= 16'd0;
            r_state   <= S_BUSY;
          end else if (w_access) begin
            misalign_err  <= 1'b1;
            mem_read_data <= 32'd0;
          end
        end
        S_BUSY: begin
          // A ready on the final allowed cycle completes rather than aborts.
          if (bus_ready) begin
            bus_req       <= 1'b0;
            mem_read_data <= bus_we ? 32'd0 : w_load_fmt;
            r_state       <= S_DONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            bus_req       <= 1'b0;
            bus_err       <= 1'b1;
            mem_read_data <= 32'd0;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Sits between the EX/MEM register and the data-memory bus, and produces the mem_read_data / mem_wb_load values captured by the MEM/WB register.
- Converts one load or store per instruction into a word-aligned request/ready bus transaction.
- Performs byte/halfword lane steering and sign/zero extension.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY without bus_ready before aborting with bus_err (1..65535)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
mem_load  input  1  EX/MEM: instruction is a load
mem_store  input  1  EX/MEM: instruction is a store (mem_load & mem_store never both set)
mem_funct3  input  3  EX/MEM: access size/sign (RV32 LB/LH/LW/LBU/LHU, SB/SH/SW encodings)
mem_addr  input  32  EX/MEM: byte address
mem_store_data  input  32  EX/MEM: rs2 value
bus_req  output  1  registered: transaction outstanding
bus_we  output  1  registered: 1=write
bus_addr  output  32  registered: {mem_addr[31:2],2'b00}
bus_wdata  output  32  registered: store data replicated into lanes
bus_wstrb  output  4  registered: byte enables (0 for reads)
bus_ready  input  1  bus completes the current transaction this cycle
bus_rdata  input  32  read word, valid when bus_ready
mem_read_data  output  32  registered formatted load result, to MEM/WB
mem_wb_load  output  1  mem_load passthrough (combinational), to MEM/WB
mem_stall  output  1  combinational: freeze PC, IF/ID, ID/EX, EX/MEM; MEM/WB holds
misalign_err  output  1  one-cycle pulse: misaligned or illegal funct3 access
bus_err  output  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, mem_read_data=0, misalign_err=0, bus_err=0, timeout counter=0. rst mid-transaction abandons it immediately; bus_req drops the next cycle.
- Access valid: access = mem_load|mem_store.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
- Alignment: half accesses need addr[0]=0; word accesses need addr[1:0]=00.
- States: IDLE, BUSY, DONE.
- IDLE:
  - access legal+aligned -> load bus_* registers, bus_req=1, counter=0, go to BUSY.
  - access illegal/misaligned -> misalign_err=1 for one cycle, no bus access, mem_read_data=0, stay IDLE.
  - no access -> stay IDLE.
- BUSY:
  - bus_ready=1 -> bus_req=0, capture the formatted load (stores: mem_read_data=0), go to DONE.
  - else counter+1; when counter reaches TIMEOUT_CYCLES-1 without ready -> bus_req=0, bus_err=1 pulse, mem_read_data=0, go to DONE.
  - A bus_ready arriving the same cycle as the timeout wins; no bus_err.
- DONE: one cycle, no new request; the same instruction is still in EX/MEM. Return to IDLE next cycle.
- mem_stall = (state==IDLE & access legal & aligned) | (state==BUSY). It is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum latency: 3 cycles per access (IDLE accept, BUSY with ready, DONE).
- Store steering (off = addr[1:0]):
  - SB: wdata = byte replicated x4, wstrb = 0001<<off.
  - SH: wdata = half replicated x2, wstrb = 0011<<off.
  - SW: wstrb = 1111.
- Load formatting: select the byte at lane off or the half at lane off[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- bus_ready outside BUSY is ignored.
- bus_* outputs hold their values while bus_req=1.

Test Plan:
- LW addr 0x100, ready after 2 wait cycles, rdata 0xDEADBEEF -> bus_req high 3 cycles, bus_addr 0x100, wstrb 0; mem_read_data 0xDEADBEEF in DONE; mem_stall high 4 cycles total.
- LB addr 0x203, rdata 0x80112233 -> mem_read_data 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x202, rdata 0x80112233 -> 0x00008011.
- SB addr 0x7, data 0x000000A5 -> bus_addr 0x4, wdata 0xA5A5A5A5, wstrb 1000, bus_we 1. SH addr 0x2, data 0x1234 -> wdata 0x12341234, wstrb 1100.
- LW addr 0x102 and SH addr 0x1 -> misalign_err one-cycle pulse, bus_req stays 0, mem_stall 0, mem_read_data 0.
- TIMEOUT_CYCLES=4, ready never asserted -> bus_req high 4 cycles, then bus_err pulse, mem_read_data 0, DONE, then IDLE. Repeat with ready on the 4th cycle -> no bus_err.
- rst asserted during BUSY -> next cycle all outputs 0, state IDLE; a later LW completes normally.
